// File: rtl/hdlc_rx_checker.sv
// Purpose: on-line HDLC receive-path protocol checker (flag, abort, idle, overflow write-guard).
// Latency: errors reach the registered outputs one edge after they are raised; flag/abort expectations trail their triggers by FLAG_LATENCY/ABORT_LATENCY.
// Backpressure: none; it only observes, never stalls the Rx datapath, and samples every cycle.
//
// Ports:
//   Clk, Rst              - rising-edge clock, asynchronous active-high reset
//   Rx                    - serial receive line (feeds the 8-bit history)
//   Rx_FlagDetect         - must be high FLAG_LATENCY cycles after a 0111_1110 pattern
//   Rx_ValidFrame         - frame in progress; qualifies abort and overflow checks
//   Rx_AbortDetect        - abort trigger (with Rx_ValidFrame)
//   Rx_AbortSignal        - must be high ABORT_LATENCY cycles after the abort trigger
//   Rx_Overflow, Rx_WrBuff- overflow and buffer write strobes for the write-guard check
//   TxEN, RxEN            - enables; both low for IDLE_GUARD cycles arms the idle check
//   CheckEn[3:0]          - per-check report mask {ovf, idle, abort, flag}
//   Clr                   - synchronous clear of reporting state (wins over same-cycle errors)
//   ErrFlags, ErrCnt      - sticky per-check flags, saturating total error count
//   FirstErrValid/Id      - capture of the first erroring check since reset or Clr
module hdlc_rx_checker #(
    parameter int FLAG_LATENCY  = 2,
    parameter int ABORT_LATENCY = 1,
    parameter int IDLE_GUARD    = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Rx_FlagDetect,
    input  logic                 Rx_ValidFrame,
    input  logic                 Rx_AbortDetect,
    input  logic                 Rx_AbortSignal,
    input  logic                 Rx_Overflow,
    input  logic                 Rx_WrBuff,
    input  logic                 TxEN,
    input  logic                 RxEN,
    input  logic [3:0]           CheckEn,
    input  logic                 Clr,
    output logic [3:0]           ErrFlags,
    output logic [CNT_WIDTH-1:0] ErrCnt,
    output logic                 FirstErrValid,
    output logic [1:0]           FirstErrId
);

    localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;
    localparam logic [3:0] GUARD_MAX    = 4'(IDLE_GUARD);

    logic [7:0]               rxHist;
    logic [FLAG_LATENCY-1:0]  flagPipe;
    logic [ABORT_LATENCY-1:0] abortPipe;
    logic [3:0]               guardCnt;
    logic                     ovfSeen;

    logic                     flagMatch;
    logic                     abortTrig;
    logic                     idleArmed;
    logic [3:0]               rawErr;
    logic [3:0]               errVec;
    logic [2:0]               errNum;
    logic [1:0]               lowId;
    logic [CNT_WIDTH+2:0]     cntSum;
    logic [CNT_WIDTH-1:0]     cntNext;

    // The match window includes the current Rx as its newest bit, so the
    // expectation starts in the same cycle the closing 0 appears.
    assign flagMatch = ({rxHist[6:0], Rx} == FLAG_PATTERN);
    assign abortTrig = Rx_AbortDetect && Rx_ValidFrame;
    // Requiring both enables low in the current cycle makes IDLE_GUARD=0 arm
    // exactly on the cycle the enables drop, not continuously.
    assign idleArmed = !TxEN && !RxEN && (guardCnt == GUARD_MAX);

    always_comb begin
        rawErr    = 4'b0000;
        rawErr[0] = flagPipe[FLAG_LATENCY-1] && !Rx_FlagDetect;
        rawErr[1] = abortPipe[ABORT_LATENCY-1] && !Rx_AbortSignal;
        rawErr[2] = idleArmed && !Rx;
        // ovfSeen is registered, so the cycle Rx_Overflow first rises is exempt.
        rawErr[3] = ovfSeen && Rx_WrBuff;
    end

    assign errVec = rawErr & CheckEn;
    assign errNum = {2'b00, errVec[0]} + {2'b00, errVec[1]}
                  + {2'b00, errVec[2]} + {2'b00, errVec[3]};

    // Scan from high to low so the lowest erroring index is left standing.
    always_comb begin
        lowId = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (errVec[i]) begin
                lowId = 2'(i);
            end
        end
    end

    // Widened add so up to four simultaneous errors saturate instead of wrapping.
    always_comb begin
        cntSum  = {3'b000, ErrCnt} + {{CNT_WIDTH{1'b0}}, errNum};
        cntNext = ErrCnt;
        if (cntSum > {3'b000, {CNT_WIDTH{1'b1}}}) begin
            cntNext = {CNT_WIDTH{1'b1}};
        end else begin
            cntNext = cntSum[CNT_WIDTH-1:0];
        end
    end

    // Observation state: runs regardless of CheckEn and is untouched by Clr.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxHist    <= 8'h00;
            flagPipe  <= '0;
            abortPipe <= '0;
            guardCnt  <= 4'd0;
            ovfSeen   <= 1'b0;
        end else begin
            rxHist    <= {rxHist[6:0], Rx};
            flagPipe  <= {flagPipe, flagMatch};
            abortPipe <= {abortPipe, abortTrig};

            if (TxEN || RxEN) begin
                guardCnt <= 4'd0;
            end else if (guardCnt != GUARD_MAX) begin
                guardCnt <= guardCnt + 4'd1;
            end

            if (!Rx_ValidFrame) begin
                ovfSeen <= 1'b0;
            end else if (Rx_Overflow) begin
                ovfSeen <= 1'b1;
            end
        end
    end

    // Reporting state.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ErrFlags      <= 4'b0000;
            ErrCnt        <= '0;
            FirstErrValid <= 1'b0;
            FirstErrId    <= 2'd0;
        end else if (Clr) begin
            ErrFlags      <= 4'b0000;
            ErrCnt        <= '0;
            FirstErrValid <= 1'b0;
            FirstErrId    <= 2'd0;
        end else begin
            ErrFlags <= ErrFlags | errVec;
            ErrCnt   <= cntNext;
            if (!FirstErrValid && (errVec != 4'b0000)) begin
                FirstErrValid <= 1'b1;
                FirstErrId    <= lowId;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Purpose: directed self-checking bench for hdlc_rx_checker (CNT_WIDTH=4 so saturation is reachable).
// Latency: inputs change 1 time unit after a rising edge and outputs are sampled there too.
// Backpressure: not applicable.
module tb_hdlc_rx_checker;

    logic       Clk;
    logic       Rst;
    logic       Rx;
    logic       Rx_FlagDetect;
    logic       Rx_ValidFrame;
    logic       Rx_AbortDetect;
    logic       Rx_AbortSignal;
    logic       Rx_Overflow;
    logic       Rx_WrBuff;
    logic       TxEN;
    logic       RxEN;
    logic [3:0] CheckEn;
    logic       Clr;
    logic [3:0] ErrFlags;
    logic [3:0] ErrCnt;
    logic       FirstErrValid;
    logic [1:0] FirstErrId;

    int nCmp = 0;
    int nMis = 0;

    hdlc_rx_checker #(
        .FLAG_LATENCY (2),
        .ABORT_LATENCY(1),
        .IDLE_GUARD   (2),
        .CNT_WIDTH    (4)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx            (Rx),
        .Rx_FlagDetect (Rx_FlagDetect),
        .Rx_ValidFrame (Rx_ValidFrame),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_Overflow   (Rx_Overflow),
        .Rx_WrBuff     (Rx_WrBuff),
        .TxEN          (TxEN),
        .RxEN          (RxEN),
        .CheckEn       (CheckEn),
        .Clr           (Clr),
        .ErrFlags      (ErrFlags),
        .ErrCnt        (ErrCnt),
        .FirstErrValid (FirstErrValid),
        .FirstErrId    (FirstErrId)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [3:0] flags, input logic [3:0] cnt,
                            input logic fev, input logic [1:0] fid);
        checkVal({tag, ".flags"}, {28'd0, ErrFlags}, {28'd0, flags});
        checkVal({tag, ".cnt"},   {28'd0, ErrCnt},   {28'd0, cnt});
        checkVal({tag, ".fev"},   {31'd0, FirstErrValid}, {31'd0, fev});
        checkVal({tag, ".fid"},   {30'd0, FirstErrId},    {30'd0, fid});
    endtask

    task automatic doClr();
        Clr = 1'b1;
        step();
        Clr = 1'b0;
    endtask

    // Shifts 0,1,1,1,1,1,1,0; returns one time unit after the edge that samples the closing 0.
    task automatic sendFlag();
        logic [7:0] bits;
        bits = 8'b0111_1110;
        for (int i = 7; i >= 0; i--) begin
            Rx = bits[i];
            step();
        end
        Rx = 1'b1;
    endtask

    // Pulses Rx_FlagDetect in the cycle that lies 'delay' cycles after the closing 0.
    task automatic flagWithDetect(input int delay);
        sendFlag();
        for (int i = 1; i < delay; i++) step();
        Rx_FlagDetect = 1'b1;
        step();
        Rx_FlagDetect = 1'b0;
        step();
        step();
    endtask

    initial begin
        Rst = 1'b1; Rx = 1'b1; Rx_FlagDetect = 1'b0; Rx_ValidFrame = 1'b0;
        Rx_AbortDetect = 1'b0; Rx_AbortSignal = 1'b0; Rx_Overflow = 1'b0;
        Rx_WrBuff = 1'b0; TxEN = 1'b1; RxEN = 1'b1; CheckEn = 4'hF; Clr = 1'b0;

        #2;
        checkAll("reset", 4'h0, 4'd0, 1'b0, 2'd0);
        step();
        step();
        Rst = 1'b0;
        step();
        step();
        checkAll("post_reset", 4'h0, 4'd0, 1'b0, 2'd0);

        // Flag detect on time: no error.
        flagWithDetect(2);
        checkVal("flag_ok.flags", {28'd0, ErrFlags}, 32'd0);
        checkVal("flag_ok.cnt",   {28'd0, ErrCnt},   32'd0);

        // Flag detect one cycle late: flag error.
        flagWithDetect(3);
        checkAll("flag_late", 4'h1, 4'd1, 1'b1, 2'd0);

        // Same late detect with the flag check masked: nothing changes.
        CheckEn = 4'b1110;
        flagWithDetect(3);
        CheckEn = 4'hF;
        checkAll("flag_masked", 4'h1, 4'd1, 1'b1, 2'd0);

        doClr();
        checkAll("clr1", 4'h0, 4'd0, 1'b0, 2'd0);

        // Abort without signal, colliding with an idle violation: both count, abort id wins.
        TxEN = 1'b0; RxEN = 1'b0;
        step();
        Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1;
        step();
        Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx = 1'b0;
        step();
        Rx = 1'b1; TxEN = 1'b1; RxEN = 1'b1;
        step();
        checkAll("abort_idle", 4'b0110, 4'd2, 1'b1, 2'd1);

        doClr();
        checkAll("clr2", 4'h0, 4'd0, 1'b0, 2'd0);

        // Idle guard: Rx=0 in the 2nd disabled cycle is tolerated, in the 3rd it is not.
        TxEN = 1'b0; RxEN = 1'b0;
        step();
        Rx = 1'b0;
        step();
        checkVal("idle_guard.flags", {28'd0, ErrFlags}, 32'd0);
        step();
        checkAll("idle_armed", 4'b0100, 4'd1, 1'b1, 2'd2);
        Rx = 1'b1; TxEN = 1'b1; RxEN = 1'b1;
        step();
        doClr();

        // Overflow write-guard: the rising cycle is exempt, a later write is not.
        Rx_ValidFrame = 1'b1; Rx_Overflow = 1'b1; Rx_WrBuff = 1'b1;
        step();
        checkVal("ovf_first.flags", {28'd0, ErrFlags}, 32'd0);
        Rx_Overflow = 1'b0;
        step();
        checkAll("ovf_write", 4'b1000, 4'd1, 1'b1, 2'd3);
        Rx_WrBuff = 1'b0; Rx_ValidFrame = 1'b0;
        step();
        Rx_WrBuff = 1'b1;
        step();
        Rx_WrBuff = 1'b0;
        step();
        checkVal("ovf_after_frame.cnt", {28'd0, ErrCnt}, 32'd1);
        doClr();

        // Error raised in the same cycle as Clr is dropped.
        TxEN = 1'b0; RxEN = 1'b0;
        step();
        step();
        Rx = 1'b0; Clr = 1'b1;
        step();
        Rx = 1'b1; Clr = 1'b0; TxEN = 1'b1; RxEN = 1'b1;
        step();
        checkAll("clr_wins", 4'h0, 4'd0, 1'b0, 2'd0);

        // Saturation: 20 idle errors into a 4-bit counter.
        TxEN = 1'b0; RxEN = 1'b0;
        step();
        step();
        Rx = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkVal("sat_mid.cnt", {28'd0, ErrCnt}, 32'd10);
        for (int i = 0; i < 10; i++) step();
        checkVal("sat_full.cnt", {28'd0, ErrCnt}, 32'd15);
        Rx = 1'b1; TxEN = 1'b1; RxEN = 1'b1;
        step();
        step();
        checkAll("sat_hold", 4'b0100, 4'd15, 1'b1, 2'd2);
        doClr();
        checkAll("clr_sat", 4'h0, 4'd0, 1'b0, 2'd0);

        // Reset pulse between the flag and its expected detect: expectation discarded.
        sendFlag();
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checkAll("rst_mid", 4'h0, 4'd0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
